unidade_controle_multiciclo: RTL and testbench
==============================================

// Module: unidade_controle_multiciclo
// PURPOSE
//  Moore FSM that sequences the multicycle RISC-V datapath (PC, IR, shared ALU, unified memory, regfile).
//  Each instruction is decoded once and driven through FETCH/DECODE/EXECUTE/MEM/WB steps.
//  Memory accesses use a mem_ready handshake that tolerates variable latency, bounded by a watchdog.
//  Supports the R-type, I-type ALU, LW, SW, BEQ and JAL instruction set, with identical ALUControl codes.
// PARAMETERS
//  MEM_WAIT_MAX     15  max cycles a memory state waits for mem_ready before the watchdog fires (1..255)
//  HALT_ON_ILLEGAL  1   1: an illegal opcode or a watchdog timeout enters HALT; 0: flag it and return to FETCH
// PORTS
//  clk         in   1  clock; all state changes occur on the rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  opcode      in   7  IR[6:0]
//  funct3      in   3  IR[14:12]
//  funct7      in   7  IR[31:25]
//  zero        in   1  ALU zero flag, valid in the BEQ state
//  mem_ready   in   1  memory completed the access requested this cycle
//  PCWrite     out  1  PC load strobe
//  IRWrite     out  1  IR/oldPC load strobe
//  RegWrite    out  1  regfile write strobe
//  MemRead     out  1  memory read request
//  MemWrite    out  1  memory write request
//  AdrSrc      out  1  memory address select: 0=PC, 1=ALUOut
//  ResultSrc   out  2  result select: 00=ALUOut, 01=mem data, 10=ALU result
//  ALUSrcA     out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1
//  ALUSrcB     out  2  ALU B select: 00=rs2, 01=imm, 10=const 4
//  ALUControl  out  4  ADD 0010, SUB 0110, OR 0001, AND 0000, SLL 0011, SRL 0101
//  state       out  4  current state, for debug
//  error       out  1  sticky; set by an illegal opcode or a watchdog timeout; cleared only by reset
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 ALUWB=7 EXECI=8 JAL=9 BEQ=10 HALT=11.
//  Reset (rst_n=0, asynchronous): state=FETCH, wait counter=0, error=0; all five strobes forced to 0 while rst_n=0.
//  Every output is a pure function of state (plus zero/mem_ready where listed). Default: strobes 0, selects 00, ALUControl=ADD.
//  FETCH: MemRead=1, AdrSrc=0, A=00, B=10, ADD, ResultSrc=10.
//    If mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold in FETCH.
//  DECODE: A=01, B=01, ADD (branch/jump target into ALUOut). Next state by opcode:
//    0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ;
//    any other opcode -> error=1, then HALT (HALT_ON_ILLEGAL=1) or FETCH (0).
//  MEMADR: A=10, B=01, ADD. Go to MEMREAD if opcode=0000011, else MEMWRITE.
//  MEMREAD: MemRead=1, AdrSrc=1. Go to MEMWB on mem_ready.
//  MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
//  MEMWRITE: MemWrite=1, AdrSrc=1. Go to FETCH on mem_ready.
//  EXECR: A=10, B=00, then ALUWB. ALUControl from funct3:
//    000 -> SUB if funct7[5] else ADD; 110 OR; 111 AND; 001 SLL; 101 SRL.
//    Any other funct3 -> ADD and error=1.
//  EXECI: A=10, B=01, then ALUWB. Same funct3 decode, but 000 is always ADD.
//  ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
//  JAL: A=01, B=10, ADD, ResultSrc=00, PCWrite=1, then ALUWB (writes oldPC+4 to rd).
//  BEQ: A=10, B=00, SUB, ResultSrc=00, PCWrite=zero, then FETCH.
//  HALT: all strobes 0; stays in HALT until reset.
//  Watchdog: counter clears on entry to FETCH, MEMREAD or MEMWRITE and counts each cycle with mem_ready=0.
//    On reaching MEM_WAIT_MAX with mem_ready still 0: error=1, then HALT or FETCH per HALT_ON_ILLEGAL.
//    mem_ready in the same cycle the limit is reached wins: normal transition, no error.
//  Latencies with zero-wait memory: R/I/JAL = 4 cycles; LW = 5; SW = 4; BEQ = 3.
//  Reset asserted mid-instruction aborts it; no strobe is issued after the asynchronous assertion.
// TESTING
//  add x3,x1,x2 (0x002081B3), mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 only in cycle 4; ALUControl=0110 for sub.
//  lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MemRead=1 throughout, MEMWB once, error=0.
//  beq with zero=1, then zero=0 -> PCWrite=1 and PCWrite=0 respectively in state 10; both return to FETCH.
//  opcode 0x7F -> error=1 and state=11 held for 20 cycles; with HALT_ON_ILLEGAL=0, state=0 next cycle.
//  mem_ready stuck 0 in FETCH, MEM_WAIT_MAX=15 -> error rises after 15 wait cycles; IRWrite never asserted.
//  rst_n pulsed low during MEMWRITE -> MemWrite drops asynchronously; state=0, error=0 after release.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// Moore control FSM for the multicycle RISC-V datapath: sequences fetch/decode/execute,
// handshakes with a variable-latency memory and guards every memory wait with a watchdog.
module unidade_controle_multiciclo #(
    parameter int MEM_WAIT_MAX    = 15,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [3:0] state,
    output logic       error
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    state_t     state_q, state_d, fault_st;
    logic [7:0] wait_q, wait_d, wait_inc;
    logic       error_q, error_d;
    logic       in_wait, timeout, f3_legal;
    logic [3:0] alu_r, alu_i;
    logic       pcw, irw, rgw, mrd, mwr;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // funct3 decode shared by EXECR and EXECI; only R-type honours the SUB bit
    always_comb begin
        f3_legal = 1'b1;
        alu_r    = ALU_ADD;
        case (funct3)
            3'b000:  alu_r = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b110:  alu_r = ALU_OR;
            3'b111:  alu_r = ALU_AND;
            3'b001:  alu_r = ALU_SLL;
            3'b101:  alu_r = ALU_SRL;
            default: f3_legal = 1'b0;
        endcase
        alu_i = (funct3 == 3'b000) ? ALU_ADD : alu_r;
    end

    assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign wait_inc = wait_q + 8'd1;
    // a ready arriving on the limit cycle still completes normally
    assign timeout  = in_wait && !mem_ready && (wait_inc == WAIT_LIMIT);
    assign fault_st = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        wait_d  = 8'd0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        error_d = 1'b1;
                        state_d = fault_st;
                    end
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI: begin
                if (!f3_legal) error_d = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
        if (timeout) begin
            error_d = 1'b1;
            state_d = fault_st;
        end else if (in_wait && !mem_ready && state_d == state_q) begin
            wait_d = wait_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        pcw        = 1'b0;
        irw        = 1'b0;
        rgw        = 1'b0;
        mrd        = 1'b0;
        mwr        = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mrd       = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = mem_ready;
                pcw       = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mrd    = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                rgw       = 1'b1;
            end
            S_MEMWRITE: begin
                mwr    = 1'b1;
                AdrSrc = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_r;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_i;
            end
            S_ALUWB:  rgw = 1'b1;
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw     = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pcw        = zero;
            end
            default: ;
        endcase
    end

    // strobes are gated by rst_n so an asynchronous reset silences them immediately
    assign PCWrite  = pcw & rst_n;
    assign IRWrite  = irw & rst_n;
    assign RegWrite = rgw & rst_n;
    assign MemRead  = mrd & rst_n;
    assign MemWrite = mwr & rst_n;
    assign state    = state_q;
    assign error    = error_q;
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Randomized bench for the multicycle control FSM; expected state traces are built per
// instruction class from wait counts and compared against a per-state control table.
module tb_unidade_controle_multiciclo;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       pcw0, irw0, rgw0, mrd0, mwr0, adr0, err0;
    logic [1:0] res0, sa0, sb0;
    logic [3:0] alu0, st0;
    logic       pcw1, irw1, rgw1, mrd1, mwr1, adr1, err1;
    logic [1:0] res1, sa1, sb1;
    logic [3:0] alu1, st1;
    logic [15:0] ctrl0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(.MEM_WAIT_MAX(15), .HALT_ON_ILLEGAL(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(pcw0), .IRWrite(irw0), .RegWrite(rgw0),
        .MemRead(mrd0), .MemWrite(mwr0), .AdrSrc(adr0), .ResultSrc(res0), .ALUSrcA(sa0),
        .ALUSrcB(sb0), .ALUControl(alu0), .state(st0), .error(err0)
    );

    unidade_controle_multiciclo #(.MEM_WAIT_MAX(15), .HALT_ON_ILLEGAL(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(pcw1), .IRWrite(irw1), .RegWrite(rgw1),
        .MemRead(mrd1), .MemWrite(mwr1), .AdrSrc(adr1), .ResultSrc(res1), .ALUSrcA(sa1),
        .ALUSrcB(sb1), .ALUControl(alu1), .state(st1), .error(err1)
    );

    assign ctrl0 = {pcw0, irw0, rgw0, mrd0, mwr0, adr0, res0, sa0, sb0, alu0};

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 4'b0110 : 4'b0010;
            3'd6:    return 4'b0001;
            3'd7:    return 4'b0000;
            3'd1:    return 4'b0011;
            3'd5:    return 4'b0101;
            default: return 4'b0010;
        endcase
    endfunction

    // control word the datapath must see in each step: {strobes5, adr, res, A, B, alu}
    function automatic logic [15:0] exp_ctrl(input int st, input logic rdy, input logic z,
                                             input logic [2:0] f3, input logic f7b5);
        case (st)
            0:       return {rdy, rdy, 3'b010, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0010};
            1:       return {5'b00000, 1'b0, 2'b00, 2'b01, 2'b01, 4'b0010};
            2:       return {5'b00000, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0010};
            3:       return {5'b00010, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010};
            4:       return {5'b00100, 1'b0, 2'b01, 2'b00, 2'b00, 4'b0010};
            5:       return {5'b00001, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010};
            6:       return {5'b00000, 1'b0, 2'b00, 2'b10, 2'b00, alu_of(f3, f7b5)};
            7:       return {5'b00100, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0010};
            8:       return {5'b00000, 1'b0, 2'b00, 2'b10, 2'b01, alu_of(f3, 1'b0)};
            9:       return {5'b10000, 1'b0, 2'b00, 2'b01, 2'b10, 4'b0010};
            10:      return {z, 4'b0000, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0110};
            default: return {5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0010};
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // wf/wm: not-ready cycles in FETCH and in the data memory state
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input int wf, input int wm, input logic exp_err,
                             input string tag);
        int   sts[$];
        logic rdys[$];
        logic [15:0] ec;
        for (int i = 0; i < wf; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
        sts.push_back(0); rdys.push_back(1'b1);
        sts.push_back(1); rdys.push_back(1'($urandom));
        case (op)
            OP_LW: begin
                sts.push_back(2); rdys.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin sts.push_back(3); rdys.push_back(1'b0); end
                sts.push_back(3); rdys.push_back(1'b1);
                sts.push_back(4); rdys.push_back(1'($urandom));
            end
            OP_SW: begin
                sts.push_back(2); rdys.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin sts.push_back(5); rdys.push_back(1'b0); end
                sts.push_back(5); rdys.push_back(1'b1);
            end
            OP_R:   begin sts.push_back(6); rdys.push_back(1'($urandom)); sts.push_back(7); rdys.push_back(1'($urandom)); end
            OP_I:   begin sts.push_back(8); rdys.push_back(1'($urandom)); sts.push_back(7); rdys.push_back(1'($urandom)); end
            OP_JAL: begin sts.push_back(9); rdys.push_back(1'($urandom)); sts.push_back(7); rdys.push_back(1'($urandom)); end
            default: begin sts.push_back(10); rdys.push_back(1'($urandom)); end
        endcase
        foreach (sts[k]) begin
            @(negedge clk);
            opcode = op; funct3 = f3; funct7 = f7; zero = z; mem_ready = rdys[k];
            #1;
            n_cmp++;
            if (st0 !== 4'(sts[k])) begin
                n_err++;
                $display("FAIL %s cyc%0d state: got %0d expected %0d", tag, k, st0, sts[k]);
            end
            ec = exp_ctrl(sts[k], rdys[k], z, f3, f7[5]);
            n_cmp++;
            if (ctrl0 !== ec) begin
                n_err++;
                $display("FAIL %s cyc%0d ctrl: got %h expected %h (state %0d)", tag, k, ctrl0, ec, sts[k]);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (st0 !== 4'd0 || err0 !== exp_err) begin
            n_err++;
            $display("FAIL %s end: state %0d error %b expected state 0 error %b", tag, st0, err0, exp_err);
        end
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        #3;
        n_cmp++;
        if ({pcw0, irw0, rgw0, mrd0, mwr0} !== 5'b0 || st0 !== 4'd0 || err0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: strobes %b state %0d error %b expected 00000/0/0",
                     {pcw0, irw0, rgw0, mrd0, mwr0}, st0, err0);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ctrl0 !== exp_ctrl(0, 1'b0, 1'b0, 3'd0, 1'b0) || st0 !== 4'd0) begin
            n_err++;
            $display("FAIL reset_release: ctrl %h state %0d expected %h state 0", ctrl0, st0,
                     exp_ctrl(0, 1'b0, 1'b0, 3'd0, 1'b0));
        end
    endtask

    task automatic test_add_sub();
        run_instr(OP_R, 3'd0, 7'b0000000, 1'b0, 0, 0, 1'b0, "add");
        run_instr(OP_R, 3'd0, 7'b0100000, 1'b0, 0, 0, 1'b0, "sub");
        run_instr(OP_I, 3'd0, 7'b0100000, 1'b0, 0, 0, 1'b0, "addi_f7");
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        logic [2:0] f3s [5];
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
        f3s = '{3'd0, 3'd6, 3'd7, 3'd1, 3'd5};
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 5)], f3s[$urandom_range(0, 4)], 7'($urandom),
                      1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0, "rand");
    endtask

    task automatic test_lw_wait();
        run_instr(OP_LW, 3'd2, 7'd0, 1'b0, 0, 3, 1'b0, "lw_wait");
        run_instr(OP_SW, 3'd2, 7'd0, 1'b0, 2, 3, 1'b0, "sw_wait");
    endtask

    task automatic test_beq();
        run_instr(OP_BEQ, 3'd0, 7'd0, 1'b1, 0, 0, 1'b0, "beq_taken");
        run_instr(OP_BEQ, 3'd0, 7'd0, 1'b0, 0, 0, 1'b0, "beq_not");
    endtask

    task automatic test_bad_funct3();
        run_instr(OP_R, 3'd2, 7'd0, 1'b0, 0, 0, 1'b1, "bad_funct3");
    endtask

    task automatic test_illegal();
        do_reset();
        @(negedge clk);
        opcode = 7'h7F; mem_ready = 1'b1;
        #1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (st0 !== 4'd1 || err0 !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_decode: state %0d error %b expected 1/0", st0, err0);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (st0 !== 4'd11 || err0 !== 1'b1 || st1 !== 4'd0 || err1 !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_entry: halt-dut %0d/%b other %0d/%b expected 11/1 0/1",
                     st0, err0, st1, err1);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            #1;
            n_cmp++;
            if (st0 !== 4'd11 || err0 !== 1'b1 || ctrl0 !== exp_ctrl(11, mem_ready, zero, funct3, 1'b0)) begin
                n_err++;
                $display("FAIL halt_hold cyc%0d: state %0d error %b ctrl %h expected 11/1/0002",
                         k, st0, err0, ctrl0);
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (err0 !== 1'b0) begin
            n_err++;
            $display("FAIL wd_clear: error %b expected 0", err0);
        end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (irw0 !== 1'b0) begin
                n_err++;
                $display("FAIL wd_irwrite edge%0d: got %b expected 0", k, irw0);
            end
            n_cmp++;
            if (k < 15) begin
                if (st0 !== 4'd0 || err0 !== 1'b0) begin
                    n_err++;
                    $display("FAIL wd_wait edge%0d: state %0d error %b expected 0/0", k, st0, err0);
                end
            end else if (st0 !== 4'd11 || err0 !== 1'b1 || st1 !== 4'd0 || err1 !== 1'b1) begin
                n_err++;
                $display("FAIL wd_fire: halt-dut %0d/%b other %0d/%b expected 11/1 0/1",
                         st0, err0, st1, err1);
            end
        end
    endtask

    task automatic test_watchdog_boundary();
        do_reset();
        mem_ready = 1'b0;
        repeat (14) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (st0 !== 4'd0 || irw0 !== 1'b1) begin
            n_err++;
            $display("FAIL wd_edge_pre: state %0d IRWrite %b expected 0/1", st0, irw0);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (st0 !== 4'd1 || err0 !== 1'b0) begin
            n_err++;
            $display("FAIL wd_edge_ready: state %0d error %b expected 1/0", st0, err0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        opcode = OP_SW; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (st0 !== 4'd5 || mwr0 !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_pre: state %0d MemWrite %b expected 5/1", st0, mwr0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pcw0, irw0, rgw0, mrd0, mwr0} !== 5'b0 || st0 !== 4'd0) begin
            n_err++;
            $display("FAIL rmid_async: strobes %b state %0d expected 00000/0",
                     {pcw0, irw0, rgw0, mrd0, mwr0}, st0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (st0 !== 4'd0 || err0 !== 1'b0 || mrd0 !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_release: state %0d error %b MemRead %b expected 0/0/1", st0, err0, mrd0);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_random();
        test_lw_wait();
        test_beq();
        test_bad_funct3();
        test_illegal();
        test_watchdog();
        test_watchdog_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
